// File: rtl/ex_sequencer.sv
// ex_sequencer: multi-cycle control FSM that sequences one instruction through
// FETCH, DECODE, EXEC, MEM and WB and drives the datapath strobes for each step.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        request to run one instruction (seen only in IDLE and DONE)
//   instr        instruction word, latched in FETCH when mem_ready=1
//   zero         ALU zero flag, decides the branch in EXEC
//   mem_ready    memory handshake completion (seen only in FETCH and MEM)
//   ALUOpF       00 add, 01 subtract, 10 use funct (EXEC only)
//   opcodeToALU  latched funct field
//   ALUSrcF      selects the immediate as ALU B operand (EXEC only)
//   branchF, jumpF, pc_write, ir_write, mem_read, mem_write,
//   reg_write, reg_dst, mem_to_reg   datapath strobes
//   busy         high in every state except IDLE
//   done, fault  one-cycle completion / abort pulses
module ex_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALUOpF,
    output logic [5:0]  opcodeToALU,
    output logic        ALUSrcF,
    output logic        branchF,
    output logic        jumpF,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        busy,
    output logic        done,
    output logic        fault
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE} stateT;

    stateT         state, stateNext;
    logic [CW-1:0] waitCnt;
    logic [5:0]    opcode, funct;
    logic          isR, isAddi, isLw, isSw, isBeq, isJ, legal, timeout;
    logic          unusedInstr;

    assign isR         = opcode == OP_R;
    assign isAddi      = opcode == OP_ADDI;
    assign isLw        = opcode == OP_LW;
    assign isSw        = opcode == OP_SW;
    assign isBeq       = opcode == OP_BEQ;
    assign isJ         = opcode == OP_J;
    assign legal       = isR | isAddi | isLw | isSw | isBeq | isJ;
    assign timeout     = waitCnt == CW'(MEM_TIMEOUT);
    assign opcodeToALU = funct;
    assign busy        = state != IDLE;
    // Only opcode and funct steer the sequencer; the operand fields go to the datapath.
    assign unusedInstr = ^instr[25:6];

    // The wait counter runs only while parked in FETCH or MEM; every other state
    // clears it, so both waits start counting from zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= '0;
            opcode  <= '0;
            funct   <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= (state == FETCH || state == MEM) ? waitCnt + 1'b1 : '0;
            if (state == FETCH && mem_ready) begin
                opcode <= instr[31:26];
                funct  <= instr[5:0];
            end
        end
    end

    // The request stays up on the timeout cycle itself, since a mem_ready
    // arriving then still completes the access.
    always_comb begin
        stateNext  = state;
        ALUOpF     = 2'b00;
        ALUSrcF    = 1'b0;
        branchF    = 1'b0;
        jumpF      = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: stateNext = start ? FETCH : IDLE;
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    stateNext = DECODE;
                end else if (timeout) begin
                    fault     = 1'b1;
                    stateNext = IDLE;
                end
            end
            DECODE: begin
                fault     = !legal;
                stateNext = legal ? EXEC : IDLE;
            end
            EXEC: begin
                ALUOpF    = isR ? 2'b10 : isBeq ? 2'b01 : 2'b00;
                ALUSrcF   = isAddi | isLw | isSw;
                branchF   = isBeq;
                jumpF     = isJ;
                pc_write  = isJ | (isBeq & zero);
                stateNext = (isLw | isSw) ? MEM : (isBeq | isJ) ? DONE : WB;
            end
            MEM: begin
                mem_read  = isLw;
                mem_write = isSw;
                if (mem_ready) begin
                    stateNext = isLw ? WB : DONE;
                end else if (timeout) begin
                    fault     = 1'b1;
                    stateNext = IDLE;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = isR;
                mem_to_reg = isLw;
                stateNext  = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = start ? FETCH : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ex_sequencer.sv
// tb_ex_sequencer: randomized and directed checks of ex_sequencer against a phase-timeline model
module tb_ex_sequencer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [1:0]  ALUOpF;
    logic [5:0]  opcodeToALU;
    logic        ALUSrcF, branchF, jumpF, pc_write, ir_write, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, busy, done, fault;
    int          passCnt = 0, checkCnt = 0;

    typedef struct packed {
        logic [1:0] aluOp;
        logic aluSrc, branch, jump, pcW, irW, mRd, mWr, rW, rDst, m2r, busy, done, fault;
    } outsT;

    typedef enum {P_START, P_FWAIT, P_FGET, P_FFAULT, P_DECODE, P_DFAULT, P_EXEC,
                  P_MWAIT, P_MGET, P_MFAULT, P_WB, P_DONE, P_IDLE} phaseT;

    ex_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ALUOpF(ALUOpF), .opcodeToALU(opcodeToALU), .ALUSrcF(ALUSrcF), .branchF(branchF),
        .jumpF(jumpF), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic outsT obs();
        return {ALUOpF, ALUSrcF, branchF, jumpF, pc_write, ir_write, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, busy, done, fault};
    endfunction

    task automatic step(input logic s, input logic mr, input logic z, input logic [31:0] in);
        @(posedge clk);
        #1;
        start = s;
        mem_ready = mr;
        zero = z;
        instr = in;
        @(negedge clk);
    endtask

    // Builds the expected phase timeline of one instruction from its class and the
    // memory delays, then plays it cycle by cycle. Cycle 0 is the cycle start is sampled.
    task automatic runInstr(input string tag, input logic [31:0] ins, input int fd, input int md,
                            input int zMode, input bit chained, input bit holdStart,
                            output int doneAt, output int faultAt, output int readCycles,
                            output bit regWSeen, output bit execPc, output bit chainOut);
        phaseT       ph[$];
        logic [5:0]  op;
        bit          legal, isLw, isMem, noWb;
        outsT        o, e;
        logic        s, mr, z;
        logic [31:0] in, r;
        int          t;
        op    = ins[31:26];
        legal = op inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02};
        isLw  = op == 6'h23;
        isMem = isLw || op == 6'h2b;
        noWb  = op inside {6'h2b, 6'h04, 6'h02};
        if (!chained) ph.push_back(P_START);
        for (int k = 0; k < fd && k < 15; k++) ph.push_back(P_FWAIT);
        if (fd > 15) ph.push_back(P_FFAULT);
        else begin
            ph.push_back(P_FGET);
            if (!legal) ph.push_back(P_DFAULT);
            else begin
                ph.push_back(P_DECODE);
                ph.push_back(P_EXEC);
                if (isMem) begin
                    for (int k = 0; k < md && k < 15; k++) ph.push_back(P_MWAIT);
                    ph.push_back(md > 15 ? P_MFAULT : P_MGET);
                end
                if (!(isMem && md > 15)) begin
                    if (!noWb) ph.push_back(P_WB);
                    ph.push_back(P_DONE);
                end
            end
        end
        chainOut = holdStart && ph[$] == P_DONE;
        if (!chainOut) ph.push_back(P_IDLE);
        doneAt = -1;
        faultAt = -1;
        readCycles = 0;
        regWSeen = 1'b0;
        execPc = 1'b0;
        foreach (ph[i]) begin
            t  = i + (chained ? 1 : 0);
            r  = $urandom();
            s  = ph[i] == P_START ? 1'b1 : ph[i] == P_DONE ? holdStart : ph[i] == P_IDLE ? 1'b0 : r[0];
            mr = ph[i] inside {P_FWAIT, P_FFAULT, P_MWAIT, P_MFAULT} ? 1'b0 :
                 ph[i] inside {P_FGET, P_MGET} ? 1'b1 : r[1];
            z  = zMode == 0 ? 1'b0 : zMode == 1 ? 1'b1 : r[2];
            in = ph[i] == P_FGET ? ins : $urandom();
            step(s, mr, z, in);
            e = '0;
            e.busy = !(ph[i] inside {P_START, P_IDLE});
            case (ph[i])
                P_FWAIT, P_FFAULT: begin
                    e.mRd = 1'b1;
                    e.fault = ph[i] == P_FFAULT;
                end
                P_FGET: begin
                    e.mRd = 1'b1;
                    e.irW = 1'b1;
                    e.pcW = 1'b1;
                end
                P_DFAULT: e.fault = 1'b1;
                P_EXEC: begin
                    e.aluOp  = op == 6'h00 ? 2'b10 : op == 6'h04 ? 2'b01 : 2'b00;
                    e.aluSrc = op inside {6'h08, 6'h23, 6'h2b};
                    e.branch = op == 6'h04;
                    e.jump   = op == 6'h02;
                    e.pcW    = op == 6'h02 || (op == 6'h04 && z);
                end
                P_MWAIT, P_MGET, P_MFAULT: begin
                    e.mRd = isLw;
                    e.mWr = !isLw;
                    e.fault = ph[i] == P_MFAULT;
                end
                P_WB: begin
                    e.rW = 1'b1;
                    e.rDst = op == 6'h00;
                    e.m2r = isLw;
                end
                P_DONE: e.done = 1'b1;
                default: ;
            endcase
            o = obs();
            checkCnt++;
            if (o !== e) $display("FAIL %s cycle %0d %s: outputs got %h expected %h", tag, t, ph[i].name(), o, e);
            else passCnt++;
            if (ph[i] == P_EXEC) begin
                checkCnt++;
                if (opcodeToALU !== ins[5:0]) $display("FAIL %s funct: got %b expected %b", tag, opcodeToALU, ins[5:0]);
                else passCnt++;
                execPc = o.pcW;
            end
            if (o.done && doneAt < 0) doneAt = t;
            if (o.fault && faultAt < 0) faultAt = t;
            if (ph[i] inside {P_MWAIT, P_MGET} && o.mRd) readCycles++;
            if (o.rW) regWSeen = 1'b1;
        end
    endtask

    task automatic test_reset();
        outsT o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = obs();
        checkCnt++;
        if (o !== '0 || opcodeToALU !== 6'd0) $display("FAIL reset_state: got %h/%b expected 0/0", o, opcodeToALU);
        else passCnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, $urandom());
            o = obs();
            checkCnt++;
            if (o !== '0) $display("FAIL idle_without_start: got %h expected 0", o);
            else passCnt++;
        end
    endtask

    task automatic test_rtype();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("rtype", 32'h00221820, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 5 || f != -1) $display("FAIL rtype_latency: done at %0d fault at %0d expected 5/-1", d, f);
        else passCnt++;
        checkCnt++;
        if (opcodeToALU !== 6'b100000) $display("FAIL rtype_funct_hold: got %b expected 100000", opcodeToALU);
        else passCnt++;
    endtask

    task automatic test_beq();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("beq_taken", 32'h10220005, 0, 0, 1, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 4 || ep !== 1'b1) $display("FAIL beq_taken: done at %0d pc_write %b expected 4/1", d, ep);
        else passCnt++;
        runInstr("beq_not_taken", 32'h10220005, 0, 0, 0, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 4 || ep !== 1'b0) $display("FAIL beq_not_taken: done at %0d pc_write %b expected 4/0", d, ep);
        else passCnt++;
    endtask

    task automatic test_jump();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("jump", 32'h08000123, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 4 || ep !== 1'b1 || rw !== 1'b0) $display("FAIL jump: done %0d pc_write %b reg_write %b expected 4/1/0", d, ep, rw);
        else passCnt++;
    endtask

    task automatic test_mem_ops();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("lw_wait", 32'h8c230004, 0, 3, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (rc != 4 || d != 9 || f != -1 || rw !== 1'b1)
            $display("FAIL lw_wait: reads %0d done %0d fault %0d reg_write %b expected 4/9/-1/1", rc, d, f, rw);
        else passCnt++;
        runInstr("lw_fast", 32'h8c230004, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 6) $display("FAIL lw_latency: got %0d expected 6", d);
        else passCnt++;
        runInstr("sw_fast", 32'hac230004, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 5 || rw !== 1'b0) $display("FAIL sw_latency: done %0d reg_write %b expected 5/0", d, rw);
        else passCnt++;
        runInstr("addi", 32'h20220007, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 5) $display("FAIL addi_latency: got %0d expected 5", d);
        else passCnt++;
    endtask

    task automatic test_faults();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("illegal", 32'hfc000000, 0, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (f != 2 || d != -1) $display("FAIL illegal_opcode: fault %0d done %0d expected 2/-1", f, d);
        else passCnt++;
        runInstr("fetch_timeout", 32'h00221820, 16, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (f != 16 || d != -1) $display("FAIL fetch_timeout: fault %0d done %0d expected 16/-1", f, d);
        else passCnt++;
        runInstr("fetch_edge", 32'h00221820, 15, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (f != -1 || d != 20) $display("FAIL fetch_ready_at_limit: fault %0d done %0d expected -1/20", f, d);
        else passCnt++;
        runInstr("mem_timeout", 32'h8c230004, 0, 16, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (f != 19 || d != -1 || rw !== 1'b0) $display("FAIL mem_timeout: fault %0d done %0d reg_write %b expected 19/-1/0", f, d, rw);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        outsT o;
        int d, f, rc;
        bit rw, ep, co;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'hac230004);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        checkCnt++;
        if (mem_write !== 1'b1) $display("FAIL sw_in_mem: mem_write got %b expected 1", mem_write);
        else passCnt++;
        #1 rst = 1'b1;
        #1;
        o = obs();
        checkCnt++;
        if (o !== '0 || opcodeToALU !== 6'd0) $display("FAIL async_reset: got %h/%b expected 0/0", o, opcodeToALU);
        else passCnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, $urandom());
            o = obs();
            checkCnt++;
            if (o !== '0) $display("FAIL after_reset_quiet: got %h expected 0", o);
            else passCnt++;
        end
        runInstr("after_reset", 32'h00430820, 1, 0, 2, 1'b0, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 6) $display("FAIL after_reset_latency: got %0d expected 6", d);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        int d, f, rc;
        bit rw, ep, co;
        runInstr("b2b_first", 32'hac230004, 0, 0, 2, 1'b0, 1'b1, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 5 || co !== 1'b1) $display("FAIL b2b_first: done %0d expected 5", d);
        else passCnt++;
        runInstr("b2b_second", 32'h00221820, 0, 0, 2, co, 1'b0, d, f, rc, rw, ep, co);
        checkCnt++;
        if (d != 5) $display("FAIL b2b_second: done %0d expected 5", d);
        else passCnt++;
    endtask

    task automatic test_random();
        logic [5:0]  ops[6];
        logic [5:0]  op;
        logic [31:0] r, r2;
        int          d, f, rc, fd, md, sel;
        bit          rw, ep, co, ch, hold;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02};
        ch = 1'b0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            sel = $urandom_range(0, 6);
            if (sel == 6) begin
                do begin
                    r2 = $urandom();
                    op = r2[5:0];
                end while (op inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02});
            end else op = ops[sel];
            fd = ($urandom_range(0, 11) == 0) ? 16 : $urandom_range(0, 3);
            md = ($urandom_range(0, 11) == 0) ? 16 : $urandom_range(0, 3);
            hold = (n < 39) ? ($urandom_range(0, 1) == 1) : 1'b0;
            runInstr("random", {op, r[25:0]}, fd, md, 2, ch, hold, d, f, rc, rw, ep, co);
            ch = co;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_beq();
        test_jump();
        test_mem_ops();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
